// File: rtl/bz_discrete_sound.sv
// bz_discrete_sound
//   CPU-addressed output latch and discrete-sound generator for the Battlezone
//   core. It captures CPU writes to LATCH_ADDR and drives the sound-enable,
//   motor and LED control lines. It also generates two LFSR-derived noise
//   toggles and the shell and explosion decay envelopes for the audio mixer.
//
// Ports
//   clk, rst_l        system clock, synchronous active-low reset
//   clk_en            CPU 3 MHz clock enable (latch writes, edge history)
//   clk_6KHz_en       sound tick enable (LFSR, noise, envelopes, prescaler)
//   addr, din, we     CPU bus address, write data and write strobe
//   latch_q           current output latch value
//   sound_en          latch_q[5]
//   noise0, noise1    LFSR toggle sources A and B
//   shell_amp         shell envelope gated by noise0 (registered)
//   expl_amp          explosion envelope gated by noise1 (registered)
//   ctrl_n            active-low external control lines (combinational)
//   dout              latch readback; 0 unless BZ_LATCH_READBACK_EN is defined
//
// Build option
//   BZ_LATCH_READBACK_EN : when defined, dout returns latch_q on a read of
//   LATCH_ADDR, registered on clk_en. When undefined, dout is tied to 0.

module bz_discrete_sound #(
  parameter logic [15:0] LATCH_ADDR  = 16'h1840,
  parameter int          DECAY_TICKS = 96,
  parameter logic [3:0]  LOUD_LEVEL  = 4'd15,
  parameter logic [3:0]  SOFT_LEVEL  = 4'd8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        clk_en,
  input  logic        clk_6KHz_en,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        we,
  output logic [7:0]  latch_q,
  output logic        sound_en,
  output logic        noise0,
  output logic        noise1,
  output logic [3:0]  shell_amp,
  output logic [3:0]  expl_amp,
  output logic [7:0]  ctrl_n,
  output logic [7:0]  dout
);

  localparam logic [7:0] PRESC_MAX = 8'(DECAY_TICKS - 1);

  logic [3:2]  prev;
  logic [15:0] lfsr;
  logic [7:0]  presc;
  logic [3:0]  shell_lvl;
  logic [3:0]  expl_lvl;

  logic latch_wr;
  logic decay;
  logic trig_shell;
  logic trig_expl;

  assign sound_en   = latch_q[5];
  assign latch_wr   = clk_en & we & (addr == LATCH_ADDR);
  assign decay      = (presc == PRESC_MAX);
  // Rising edge of a trigger bit relative to the last history snapshot.
  assign trig_shell = latch_q[3] & ~prev[3];
  assign trig_expl  = latch_q[2] & ~prev[2];

  // Envelope priority: sound off > trigger load > decay step (saturating).
  function automatic logic [3:0] env_next(input logic [3:0] lvl,
                                          input logic       snd,
                                          input logic       trig,
                                          input logic       loud,
                                          input logic       dec);
    logic [3:0] r;
    r = lvl;
    if (!snd)                  r = 4'd0;
    else if (trig)             r = loud ? LOUD_LEVEL : SOFT_LEVEL;
    else if (dec && lvl != 0)  r = lvl - 4'd1;
    return r;
  endfunction

  // Latch and edge history. A tick also snapshots the history so a pending
  // trigger fires exactly once.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      latch_q <= 8'h00;
      prev    <= 2'b00;
    end else begin
      if (clk_en | clk_6KHz_en) prev <= latch_q[3:2];
      if (latch_wr)             latch_q <= din;
    end
  end

  // Sound tick domain: LFSR, noise toggles, prescaler, envelopes.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      lfsr      <= 16'h0000;
      noise0    <= 1'b0;
      noise1    <= 1'b0;
      presc     <= 8'h00;
      shell_lvl <= 4'd0;
      expl_lvl  <= 4'd0;
    end else if (clk_6KHz_en) begin
      // Noise taps use the pre-shift register value.
      if (lfsr[15])             noise0 <= ~noise0;
      if (lfsr[14:11] != 4'hF)  noise1 <= ~noise1;
      if (!sound_en) lfsr <= 16'h0000;
      else           lfsr <= {lfsr[14:0], ~(lfsr[3] ^ lfsr[14])};
      presc     <= decay ? 8'h00 : presc + 8'h01;
      shell_lvl <= env_next(shell_lvl, sound_en, trig_shell, latch_q[1], decay);
      expl_lvl  <= env_next(expl_lvl,  sound_en, trig_expl,  latch_q[0], decay);
    end
  end

  // Mixer outputs lag the level/noise registers by one clk.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      shell_amp <= 4'd0;
      expl_amp  <= 4'd0;
    end else begin
      shell_amp <= noise0 ? shell_lvl : 4'd0;
      expl_amp  <= noise1 ? expl_lvl  : 4'd0;
    end
  end

  always_comb begin
    ctrl_n    = 8'hFF;
    ctrl_n[0] = ~latch_q[3];
    ctrl_n[1] = ~latch_q[2];
    ctrl_n[2] = ~noise0;
    ctrl_n[3] = ~latch_q[1];
    ctrl_n[4] = ~latch_q[0];
    ctrl_n[5] = ~noise1;
    ctrl_n[6] = sound_en ? ~latch_q[7] : 1'b1;
    ctrl_n[7] = sound_en ? ~latch_q[4] : 1'b1;
  end

`ifdef BZ_LATCH_READBACK_EN
  logic [7:0] dout_q;

  always_ff @(posedge clk) begin
    if (!rst_l)      dout_q <= 8'h00;
    else if (clk_en) dout_q <= (addr == LATCH_ADDR && !we) ? latch_q : 8'h00;
  end

  assign dout = dout_q;
`else
  assign dout = 8'h00;
`endif

endmodule

// File: tb/tb_bz_discrete_sound.sv
// Self-checking bench for bz_discrete_sound (DECAY_TICKS=4 so envelopes
// finish quickly). A table of latch writes, directed envelope/LFSR sequences
// and a randomized run are all checked against a cycle model kept here.

module tb_bz_discrete_sound;

  localparam logic [15:0] ADDR = 16'h1840;
  localparam int          DT   = 4;
`ifdef BZ_LATCH_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        clk_en = 1'b0;
  logic        clk_6KHz_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  latch_q;
  logic        sound_en;
  logic        noise0;
  logic        noise1;
  logic [3:0]  shell_amp;
  logic [3:0]  expl_amp;
  logic [7:0]  ctrl_n;
  logic [7:0]  dout;

  bz_discrete_sound #(.LATCH_ADDR(ADDR), .DECAY_TICKS(DT)) dut (
    .clk(clk), .rst_l(rst_l), .clk_en(clk_en), .clk_6KHz_en(clk_6KHz_en),
    .addr(addr), .din(din), .we(we), .latch_q(latch_q), .sound_en(sound_en),
    .noise0(noise0), .noise1(noise1), .shell_amp(shell_amp),
    .expl_amp(expl_amp), .ctrl_n(ctrl_n), .dout(dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0]  m_latch, m_dout;
  logic [3:2]  m_prev;
  logic [15:0] m_lfsr;
  logic        m_n0, m_n1;
  logic [3:0]  m_sl, m_el, m_samp, m_eamp;
  int          m_ticks;
  int          m_tog0, m_tog1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_ctrl(input logic [7:0] l, input logic n0, input logic n1);
    logic [7:0] r;
    r[0] = ~l[3]; r[1] = ~l[2]; r[2] = ~n0; r[3] = ~l[1];
    r[4] = ~l[0]; r[5] = ~n1;
    r[6] = l[5] ? ~l[7] : 1'b1;
    r[7] = l[5] ? ~l[4] : 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] env(input logic [3:0] lvl, input logic snd,
                                     input logic trig, input logic loud, input logic dec);
    if (!snd) return 4'd0;
    if (trig) return loud ? 4'd15 : 4'd8;
    if (dec && lvl > 0) return lvl - 4'd1;
    return lvl;
  endfunction

  task automatic model_clk(input bit r, input bit ce, input bit tk,
                           input logic [15:0] a, input logic [7:0] d, input bit w);
    bit dec, ts, te;
    if (!r) begin
      m_latch = 0; m_prev = 0; m_lfsr = 0; m_n0 = 0; m_n1 = 0;
      m_sl = 0; m_el = 0; m_samp = 0; m_eamp = 0; m_dout = 0; m_ticks = 0;
      return;
    end
    m_samp = m_n0 ? m_sl : 4'd0;
    m_eamp = m_n1 ? m_el : 4'd0;
    if (RB && ce) m_dout = (a == ADDR && !w) ? m_latch : 8'h00;
    if (tk) begin
      dec = (m_ticks % DT) == DT - 1;
      ts  = m_latch[3] && !m_prev[3];
      te  = m_latch[2] && !m_prev[2];
      if (m_lfsr[15]) begin m_n0 = !m_n0; m_tog0++; end
      if (m_lfsr[14:11] != 4'hF) begin m_n1 = !m_n1; m_tog1++; end
      m_lfsr = m_latch[5] ? {m_lfsr[14:0], ~(m_lfsr[3] ^ m_lfsr[14])} : 16'h0;
      m_sl = env(m_sl, m_latch[5], ts, m_latch[1], dec);
      m_el = env(m_el, m_latch[5], te, m_latch[0], dec);
      m_ticks++;
    end
    if (ce || tk) m_prev = m_latch[3:2];
    if (ce && w && a == ADDR) m_latch = d;
  endtask

  task automatic cyc(input bit r, input bit ce, input bit tk,
                     input logic [15:0] a, input logic [7:0] d, input bit w);
    rst_l = r; clk_en = ce; clk_6KHz_en = tk; addr = a; din = d; we = w;
    @(posedge clk);
    model_clk(r, ce, tk, a, d, w);
    #1;
    chk("latch_q",   latch_q,   m_latch);
    chk("sound_en",  sound_en,  m_latch[5]);
    chk("noise0",    noise0,    m_n0);
    chk("noise1",    noise1,    m_n1);
    chk("shell_amp", shell_amp, m_samp);
    chk("expl_amp",  expl_amp,  m_eamp);
    chk("ctrl_n",    ctrl_n,    exp_ctrl(m_latch, m_n0, m_n1));
    chk("dout",      dout,      m_dout);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1, 1, 0, a, d, 1);
  endtask

  task automatic tick();
    cyc(1, 0, 1, 16'h0, 8'h0, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 16'h0, 8'h0, 0);
    cyc(1, 0, 0, 16'h0, 8'h0, 0);
  endtask

  typedef struct {
    bit          ce;
    logic [15:0] a;
    logic [7:0]  d;
    bit          w;
    logic [7:0]  e_latch;
    logic [7:0]  e_ctrl;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 16'h1840, 8'hA0, 1'b1, 8'hA0, 8'hBF, 8'h00};
    tbl[1] = '{1'b1, 16'h1840, 8'h80, 1'b1, 8'h80, 8'hFF, 8'h00};
    tbl[2] = '{1'b1, 16'h1840, 8'h34, 1'b1, 8'h34, 8'h7D, 8'h00};
    tbl[3] = '{1'b1, 16'h1841, 8'h70, 1'b1, 8'h34, 8'h7D, 8'h00};
    tbl[4] = '{1'b0, 16'h1840, 8'hFF, 1'b1, 8'h34, 8'h7D, 8'h00};
    tbl[5] = '{1'b1, 16'h1840, 8'h0F, 1'b0, 8'h34, 8'h7D, RB ? 8'h34 : 8'h00};
    tbl[6] = '{1'b1, 16'h1840, 8'h1B, 1'b1, 8'h1B, 8'hE6, 8'h00};
    tbl[7] = '{1'b1, 16'h1840, 8'hC0, 1'b1, 8'hC0, 8'hFF, 8'h00};
    tbl[8] = '{1'b1, 16'h1840, 8'hF0, 1'b1, 8'hF0, 8'h3F, 8'h00};

    // Reset state.
    do_reset();
    chk("rst_ctrl_n",  ctrl_n,    8'hFF);
    chk("rst_latch",   latch_q,   8'h00);
    chk("rst_shell",   shell_amp, 4'd0);
    chk("rst_expl",    expl_amp,  4'd0);

    // Latch writes, address/enable filtering, ctrl_n mapping.
    foreach (tbl[i]) begin
      cyc(1, tbl[i].ce, 0, tbl[i].a, tbl[i].d, tbl[i].w);
      chk($sformatf("tbl%0d_latch", i), latch_q, tbl[i].e_latch);
      chk($sformatf("tbl%0d_ctrl",  i), ctrl_n,  tbl[i].e_ctrl);
      chk($sformatf("tbl%0d_dout",  i), dout,    tbl[i].e_dout);
    end

    // LFSR from zero with sound on, then sound off clears it.
    do_reset();
    wr(ADDR, 8'h20);
    begin
      int d0, d1;
      logic p0, p1;
      d0 = 0; d1 = 0; m_tog0 = 0; m_tog1 = 0;
      p0 = noise0; p1 = noise1;
      for (int i = 0; i < 16; i++) begin
        tick();
        chk("lfsr", dut.lfsr, m_lfsr);
        if (noise0 != p0) d0++;
        if (noise1 != p1) d1++;
        p0 = noise0; p1 = noise1;
      end
      chk("tog0", d0, m_tog0);
      chk("tog1", d1, m_tog1);
    end
    wr(ADDR, 8'h00);
    tick();
    chk("lfsr_clear", dut.lfsr, 16'h0);

    // Shell loud trigger and full decay to 0.
    do_reset();
    wr(ADDR, 8'h2A);
    tick();
    chk("shell_load", dut.shell_lvl, 4'd15);
    for (int i = 0; i < 58; i++) begin tick(); cyc(1, 0, 0, 16'h0, 8'h0, 0); end
    chk("shell_one", dut.shell_lvl, 4'd1);
    tick();
    chk("shell_zero", dut.shell_lvl, 4'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("shell_stay0", dut.shell_lvl, 4'd0);

    // Explosion soft trigger, then retrigger on a decay tick.
    wr(ADDR, 8'h24);
    tick();
    chk("expl_load", dut.expl_lvl, 4'd8);
    begin
      int n;
      n = 0;
      while (!(m_el < 8 && (m_ticks % DT) == DT - 1) && n < 20) begin tick(); n++; end
      chk("align_budget", n < 20, 1'b1);
    end
    wr(ADDR, 8'h20);
    wr(ADDR, 8'h24);
    tick();
    chk("expl_retrig", dut.expl_lvl, 4'd8);

    // Wrong address ignored; readback.
    do_reset();
    wr(ADDR, 8'h34);
    wr(16'h1841, 8'h70);
    chk("badaddr_latch", latch_q, 8'h34);
    cyc(1, 1, 0, ADDR, 8'h00, 0);
    chk("readback", dout, RB ? 8'h34 : 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [15:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      a = (sel < 2) ? ADDR : (sel == 2) ? 16'h1841 : 16'($urandom);
      cyc(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, a, 8'($urandom), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bz_discrete_sound.md
Name: bz_discrete_sound

Overview:
- CPU-addressed output latch and discrete-sound generator for the Battlezone core.
- Sits directly downstream of the 6502 address decoder on the POKEY/IO bus slot.
- Captures writes to 0x1840 and produces the sound-enable, motor and LED control lines.
- Also produces two LFSR noise sources and the shell and explosion decay envelopes for the audio mixer.

Parameters:
- LATCH_ADDR, 16'h1840, CPU address of the output latch.
- DECAY_TICKS, 96, number of clk_6KHz_en ticks per one-step envelope decrement (range 1..255).
- LOUD_LEVEL, 15, envelope start level when the loud bit is set.
- SOFT_LEVEL, 8, envelope start level when the loud bit is clear.

Ports:
- clk, input, 1, system clock.
- rst_l, input, 1, reset. Synchronous, active-low.
- clk_en, input, 1, CPU 3 MHz clock enable.
- clk_6KHz_en, input, 1, sound tick enable.
- addr, input, 16, CPU bus address.
- din, input, 8, CPU write data.
- we, input, 1, CPU write strobe.
- latch_q, output, 8, current output latch value.
- sound_en, output, 1, latch_q[5].
- noise0, output, 1, LFSR toggle source A.
- noise1, output, 1, LFSR toggle source B.
- shell_amp, output, 4, gated shell envelope.
- expl_amp, output, 4, gated explosion envelope.
- ctrl_n, output, 8, active-low external control lines.
- dout, output, 8, readback data (optional feature only; otherwise 0).

Behaviour:
- Reset (rst_l=0 at a clk edge) clears everything on that edge, regardless of clk_en or clk_6KHz_en:
  - latch_q, its edge-history copy, LFSR, noise0/noise1, both envelope levels and the prescaler go to 0.
  - Resulting ctrl_n = 8'hFF; shell_amp = expl_amp = 0.
- Latch:
  - Loads din on the edge where clk_en & we & (addr==LATCH_ADDR).
  - Otherwise holds. Latency 1 clk.
  - Bit map: 7 motor, 6 start LED, 5 sound enable, 4 engine-rev, 3 shell trigger, 2 explosion trigger, 1 shell loud, 0 explosion loud.
- Edge history:
  - On every clk_en, prev[3:2] <= latch_q[3:2].
  - A trigger is pending when latch_q[n] & ~prev[n] at a clk_6KHz_en tick. The pending trigger is consumed at that tick.
- LFSR (16 bit):
  - On clk_6KHz_en: if sound_en==0, cleared to 0.
  - Otherwise shifts left, with bit0 = ~(q[3]^q[14]).
  - The all-ones state is legal and not special-cased.
- Noise:
  - On clk_6KHz_en, noise0 toggles if q[15]==1.
  - On clk_6KHz_en, noise1 toggles if q[14:11]!=4'hF.
  - Both use the pre-shift q.
- Envelopes (shell and explosion identical, each 4 bit):
  - Prescaler 8-bit counter counts clk_6KHz_en ticks 0..DECAY_TICKS-1 and wraps. The wrap tick is the decay tick.
  - Priority per tick:
    - sound_en==0 forces the level to 0.
    - Else a trigger loads LOUD_LEVEL if the loud bit is 1, otherwise SOFT_LEVEL.
    - Else on a decay tick with level>0, level decrements by 1.
  - Trigger and decay on the same tick: the trigger wins.
  - Level saturates at 0 (no wrap).
- Outputs:
  - shell_amp = noise0 ? shell_lvl : 0.
  - expl_amp = noise1 ? expl_lvl : 0.
  - Both are registered 1 clk after the level/noise update.
- ctrl_n:
  - [0] = ~latch_q[3]; [1] = ~latch_q[2]; [2] = ~noise0; [3] = ~latch_q[1]; [4] = ~latch_q[0]; [5] = ~noise1.
  - [6] = sound_en ? ~latch_q[7] : 1.
  - [7] = sound_en ? ~latch_q[4] : 1.
  - These are combinational from the registers.
- Writes to any other address are ignored.
- A write while clk_en=0 is ignored.

Optional Feature:
- BZ_LATCH_READBACK_EN defined:
  - dout is registered on clk_en.
  - dout = latch_q when addr==LATCH_ADDR & ~we, else 8'h00.
- Undefined: dout tied to 8'h00 and no readback register is built.

Test Plan:
- Reset with rst_l=0 for 3 clks, then release -> ctrl_n==8'hFF, latch_q==0, shell_amp==0, expl_amp==0.
- Write 8'hA0 to 0x1840 with clk_en=1 -> latch_q==8'hA0 next clk; ctrl_n[6]==0, ctrl_n[7]==1.
  - Then write 8'h80 -> ctrl_n[6]==1 (sound disabled).
- Sound on (8'h20), run 16 6KHz ticks -> LFSR sequence matches the xnor(3,14) reference model from 0.
  - noise0/noise1 toggle counts match the model.
  - Writing 8'h00 clears the LFSR on the next tick.
- Write 8'h2A (shell + loud) -> after the next tick shell_lvl==15.
  - With DECAY_TICKS=4, the level reaches 0 after 60 ticks and stays 0.
  - shell_amp==shell_lvl whenever noise0==1.
- Write 8'h24 (explosion, soft) -> expl_lvl==8.
  - Retrigger by writing 8'h20, then 8'h24, on a decay-wrap tick -> level reloads to 8, not 7.
- Write 8'h34 then 8'h70 to 0x1841 -> latch unchanged.
  - With BZ_LATCH_READBACK_EN, a read of 0x1840 returns 8'h34; without it, dout==0.
